hera_mem: RTL and testbench

Memory and I/O subsystem that sits directly downstream of the HERA core's single memory port. It supplies program and data storage, a small memory-mapped I/O window, and a byte-serial program loader that holds the core in reset while it fills code memory. The core drives `addr`, `code` and `write`, drives its write data on `data_out`, and expects read data back on `data_in` within the same cycle. This block is the single place where the core's address space is decoded.

---
 rtl/hera_mem.sv | 141 ++++++++++++++
 tb/tb_hera_mem.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hera_mem.sv
// HERA memory and I/O subsystem: code/data storage, a 16-word I/O window with a
// free-running timer, and a byte-serial code loader that holds the core in reset.
module hera_mem #(
   parameter int unsigned CODE_AW = 10,
   parameter int unsigned DATA_AW = 10,
   parameter logic [15:0] IO_BASE = 16'hFFF0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [15:0]        cpu_addr,
   input  logic               cpu_code,
   input  logic               cpu_write,
   input  logic [15:0]        cpu_wdata,
   output logic [15:0]        cpu_rdata,
   output logic               core_reset,
   input  logic               ld_mode,
   input  logic               ld_valid,
   input  logic [7:0]         ld_data,
   output logic               ld_ready,
   output logic [CODE_AW-1:0] ld_ptr,
   input  logic [15:0]        io_in,
   output logic [15:0]        io_out,
   output logic               io_strobe
);
   localparam int unsigned DW         = 16;
   localparam int unsigned CODE_DEPTH = 1 << CODE_AW;
   localparam int unsigned DATA_DEPTH = 1 << DATA_AW;

   typedef enum logic {LD_HI, LD_LO} ld_state_e;

   logic [DW-1:0] code_mem [CODE_DEPTH];
   logic [DW-1:0] data_mem [DATA_DEPTH];

   ld_state_e          state_q, state_d;
   logic [7:0]         hi_q, hi_d;
   logic [CODE_AW-1:0] ld_ptr_q, ld_ptr_d;
   logic               rq_q, rq_d;
   logic [DW-1:0]      io_out_q, io_out_d;
   logic               io_strobe_q, io_strobe_d;
   logic [DW-1:0]      timer_q, timer_d;

   logic          io_sel;
   logic [3:0]    io_off;
   logic          cpu_we, data_we, io_we_out, io_we_tmr;
   logic          ld_accept, mode_edge;
   logic          code_we;
   logic [DW-1:0] code_wdata;

   assign core_reset = reset | rq_q;
   assign ld_ready   = ld_mode & ~reset;
   assign ld_ptr     = ld_ptr_q;
   assign io_out     = io_out_q;
   assign io_strobe  = io_strobe_q;

   // Address decode for the core's single memory port
   assign io_sel    = (cpu_addr >= IO_BASE);
   assign io_off    = 4'(cpu_addr - IO_BASE);
   assign cpu_we    = cpu_write & ~cpu_code & ~core_reset;
   assign data_we   = cpu_we & ~io_sel;
   assign io_we_out = cpu_we & io_sel & (io_off == 4'd0);
   assign io_we_tmr = cpu_we & io_sel & (io_off == 4'd2);

   assign ld_accept = ld_valid & ld_ready;
   assign mode_edge = ld_mode ^ rq_q;

   always_comb begin
      cpu_rdata = '0;
      if (cpu_code) begin
         cpu_rdata = code_mem[cpu_addr[CODE_AW-1:0]];
      end else if (io_sel) begin
         case (io_off)
            4'd0:    cpu_rdata = io_out_q;
            4'd1:    cpu_rdata = io_in;
            4'd2:    cpu_rdata = timer_q;
            default: cpu_rdata = '0;
         endcase
      end else begin
         cpu_rdata = data_mem[cpu_addr[DATA_AW-1:0]];
      end
   end

   always_comb begin
      io_out_d    = io_out_q;
      io_strobe_d = io_we_out;
      timer_d     = timer_q;
      rq_d        = ld_mode;
      if (io_we_out) io_out_d = cpu_wdata;
      // A CPU write to the timer replaces that cycle's increment
      if (io_we_tmr)        timer_d = cpu_wdata;
      else if (!core_reset) timer_d = timer_q + DW'(1);
   end

   // Loader: any ld_mode edge restarts at word 0 with no pending high byte
   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      ld_ptr_d   = ld_ptr_q;
      code_we    = 1'b0;
      code_wdata = {hi_q, ld_data};
      if (mode_edge) begin
         state_d  = LD_HI;
         ld_ptr_d = '0;
      end
      if (ld_accept) begin
         if (mode_edge || state_q == LD_HI) begin
            hi_d    = ld_data;
            state_d = LD_LO;
         end else begin
            code_we  = 1'b1;
            ld_ptr_d = ld_ptr_q + CODE_AW'(1);
            state_d  = LD_HI;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= LD_HI;
         hi_q        <= '0;
         ld_ptr_q    <= '0;
         rq_q        <= 1'b1;
         io_out_q    <= '0;
         io_strobe_q <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         ld_ptr_q    <= ld_ptr_d;
         rq_q        <= rq_d;
         io_out_q    <= io_out_d;
         io_strobe_q <= io_strobe_d;
         timer_q     <= timer_d;
      end
   end

   // Storage arrays are deliberately not reset
   always_ff @(posedge clock) begin
      if (code_we) code_mem[ld_ptr_q] <= code_wdata;
      if (data_we) data_mem[cpu_addr[DATA_AW-1:0]] <= cpu_wdata;
   end
endmodule

// File: tb/tb_hera_mem.sv
// Self-checking bench for hera_mem: directed loader/IO sequences, a vector table,
// and randomized traffic checked every cycle against a behavioural model.
module tb_hera_mem;
   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, io_in, io_out;
   logic        cpu_code, cpu_write, core_reset;
   logic        ld_mode, ld_valid, ld_ready, io_strobe;
   logic [7:0]  ld_data;
   logic [9:0]  ld_ptr;

   hera_mem dut (
      .clock(clock), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_code(cpu_code), .cpu_write(cpu_write),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .core_reset(core_reset),
      .ld_mode(ld_mode), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_ptr(ld_ptr),
      .io_in(io_in), .io_out(io_out), .io_strobe(io_strobe)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [15:0] m_code [1024];
   bit          m_code_k [1024];
   logic [15:0] m_data [1024];
   bit          m_data_k [1024];
   logic [7:0]  pend [$];
   bit          m_rq;
   logic [15:0] m_io, m_timer;
   bit          m_strobe;
   int          m_ptr;

   typedef struct {
      logic [15:0] addr;
      logic        code;
      logic        wr;
      logic [15:0] wdata;
      logic [15:0] io_in;
      bit          chk;
      logic [15:0] exp_rd;
      logic        exp_stb;
   } vec_t;
   vec_t tbl [$];

   task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp1(input string name, input logic act, input logic exp);
      cmp16(name, 16'(act), 16'(exp));
   endtask

   task automatic model_reset();
      m_rq = 1'b1; m_io = '0; m_strobe = 1'b0; m_timer = '0; m_ptr = 0;
      pend.delete();
   endtask

   task automatic model_read(output logic [15:0] er, output bit known);
      int idx;
      idx = int'(cpu_addr) % 1024;
      known = 1'b1;
      if (cpu_code) begin
         er = m_code[idx]; known = m_code_k[idx];
      end else if (cpu_addr >= 16'hFFF0) begin
         case (int'(cpu_addr) - 'hFFF0)
            0:       er = m_io;
            1:       er = io_in;
            2:       er = m_timer;
            default: er = 16'h0000;
         endcase
      end else begin
         er = m_data[idx]; known = m_data_k[idx];
      end
   endtask

   task automatic model_step();
      bit running, tw, stb;
      int idx;
      if (reset) begin
         model_reset();
         return;
      end
      running = !m_rq;
      tw = 1'b0; stb = 1'b0;
      if (running && cpu_write && !cpu_code) begin
         if (cpu_addr >= 16'hFFF0) begin
            if (int'(cpu_addr) - 'hFFF0 == 0) begin m_io = cpu_wdata; stb = 1'b1; end
            if (int'(cpu_addr) - 'hFFF0 == 2) begin m_timer = cpu_wdata; tw = 1'b1; end
         end else begin
            idx = int'(cpu_addr) % 1024;
            m_data[idx] = cpu_wdata; m_data_k[idx] = 1'b1;
         end
      end
      if (!tw && running) m_timer = m_timer + 16'd1;
      m_strobe = stb;
      if (ld_mode != m_rq) begin pend.delete(); m_ptr = 0; end
      if (ld_mode && ld_valid) begin
         pend.push_back(ld_data);
         if (pend.size() == 2) begin
            m_code[m_ptr] = {pend[0], pend[1]};
            m_code_k[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % 1024;
            pend.delete();
         end
      end
      m_rq = ld_mode;
   endtask

   task automatic check_model();
      logic [15:0] er;
      bit known;
      cmp1("core_reset", core_reset, reset | m_rq);
      cmp1("ld_ready", ld_ready, ld_mode & ~reset);
      cmp16("ld_ptr", 16'(ld_ptr), 16'(m_ptr));
      cmp16("io_out", io_out, m_io);
      cmp1("io_strobe", io_strobe, m_strobe);
      model_read(er, known);
      if (known) cmp16("cpu_rdata", cpu_rdata, er);
   endtask

   // Called at posedge+1: check, advance one edge, return at posedge+1
   task automatic tick();
      #1 check_model();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_valid = 1'b1; ld_data = b;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic rd_code(input string name, input logic [15:0] a, input logic [15:0] exp);
      cpu_code = 1'b1; cpu_write = 1'b0; cpu_addr = a;
      #1 cmp16(name, cpu_rdata, exp);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; cpu_addr = '0; cpu_code = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
      io_in = '0; ld_mode = 1'b0; ld_valid = 1'b0; ld_data = '0;
      model_reset();
      #2;
      cmp1("rst_core_reset", core_reset, 1'b1);
      cmp1("rst_ld_ready", ld_ready, 1'b0);
      cmp16("rst_ld_ptr", 16'(ld_ptr), 16'h0);
      cmp16("rst_io_out", io_out, 16'h0);
      cmp1("rst_io_strobe", io_strobe, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Preload words 0..3
      ld_mode = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      ld_mode = 1'b0;
      tick(); tick();

      // Basic load of two words
      ld_mode = 1'b1;
      tick();
      send_byte(8'hE1); send_byte(8'h05); send_byte(8'hF1); send_byte(8'h12);
      tick();
      cmp16("ptr_before_drop", 16'(ld_ptr), 16'd2);
      ld_mode = 1'b0;
      #1 cmp1("core_reset_before_edge", core_reset, 1'b1);
      tick();
      cmp1("core_reset_after_edge", core_reset, 1'b0);
      cmp16("ptr_after_drop", 16'(ld_ptr), 16'd0);
      rd_code("code_w0", 16'h0000, 16'hE105);
      rd_code("code_w1", 16'h0001, 16'hF112);

      // Orphan high byte is discarded on drop
      ld_mode = 1'b1;
      tick();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      ld_mode = 1'b0;
      tick(); tick();
      ld_mode = 1'b1;
      tick();
      send_byte(8'hAB); send_byte(8'hCD);
      ld_mode = 1'b0;
      tick(); tick();
      rd_code("reload_w0", 16'h0000, 16'hABCD);
      rd_code("reload_w1", 16'h0001, 16'hF112);

      // CPU-side vector table
      tbl.push_back('{16'h0007, 1'b0, 1'b1, 16'h1234, 16'h0, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{16'h0407, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h1234, 1'b0});
      tbl.push_back('{16'h0003, 1'b1, 1'b1, 16'hFFFF, 16'h0, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{16'h0003, 1'b1, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0708, 1'b0});
      tbl.push_back('{16'h0403, 1'b1, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0708, 1'b0});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b1, 16'hBEEF, 16'h0, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'hBEEF, 1'b1});
      tbl.push_back('{16'hFFF1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 16'h5A5A, 1'b0});
      tbl.push_back('{16'hFFF5, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
      tbl.push_back('{16'hFFF2, 1'b0, 1'b1, 16'hFFFE, 16'h0, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{16'hFFF2, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'hFFFE, 1'b0});
      tbl.push_back('{16'hFFF2, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'hFFFF, 1'b0});
      tbl.push_back('{16'hFFF2, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b1, 16'h0001, 1'b1});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0002, 1'b1});
      tbl.push_back('{16'hFFF0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h0002, 1'b0});
      foreach (tbl[i]) begin
         cpu_addr = tbl[i].addr; cpu_code = tbl[i].code; cpu_write = tbl[i].wr;
         cpu_wdata = tbl[i].wdata; io_in = tbl[i].io_in;
         #1;
         if (tbl[i].chk) cmp16($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].exp_rd);
         cmp1($sformatf("tbl%0d_strobe", i), io_strobe, tbl[i].exp_stb);
         tick();
      end
      cpu_write = 1'b0;

      // Reset asserted while a high byte is pending
      ld_mode = 1'b1;
      tick();
      send_byte(8'h77);
      reset = 1'b1;
      model_reset();
      #1;
      cmp1("midload_ld_ready", ld_ready, 1'b0);
      cmp1("midload_core_reset", core_reset, 1'b1);
      cmp16("midload_ld_ptr", 16'(ld_ptr), 16'd0);
      tick();
      reset = 1'b0;
      send_byte(8'h11); send_byte(8'h22);
      ld_mode = 1'b0;
      tick(); tick();
      rd_code("after_reset_w0", 16'h0000, 16'h1122);
      rd_code("after_reset_w3", 16'h0003, 16'h0708);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         bit rise;
         rise = 1'b0;
         if ($urandom_range(0, 99) < 3) begin
            ld_mode = ~ld_mode;
            rise = ld_mode;
         end
         ld_valid = rise ? 1'b0 : 1'($urandom_range(0, 1));
         ld_data  = 8'($urandom);
         cpu_code  = 1'($urandom_range(0, 1));
         cpu_write = ($urandom_range(0, 2) == 0);
         cpu_wdata = 16'($urandom);
         io_in     = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       cpu_addr = 16'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 16'h0400 : 16'h8000);
            1:       cpu_addr = 16'hFFF0 + 16'($urandom_range(0, 15));
            2:       cpu_addr = 16'($urandom);
            default: cpu_addr = 16'($urandom_range(0, 15));
         endcase
         tick();
      end

      // Loader pointer wraps past the top of code memory
      cpu_write = 1'b0; ld_valid = 1'b0; ld_mode = 1'b0;
      tick();
      ld_mode = 1'b1;
      tick();
      for (int n = 0; n < 2050; n++) send_byte(8'($urandom));
      tick();
      cmp16("ptr_wrap", 16'(ld_ptr), 16'd1);
      ld_mode = 1'b0;
      tick(); tick();
      cpu_code = 1'b1; cpu_addr = 16'h0000;
      tick();
      cpu_addr = 16'h03FF;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
